// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, next-PC select encodings, NOP and FSM states.
// The FAULT state exists only when IFU_MISALIGN_TRAP_EN is defined.
package inst_fetch_unit_pkg;

  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;

  localparam logic [1:0] NPC_SEL_SEQ  = 2'd0;
  localparam logic [1:0] NPC_SEL_BR   = 2'd1;
  localparam logic [1:0] NPC_SEL_JALR = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_HALTED
`ifdef IFU_MISALIGN_TRAP_EN
    , ST_FAULT
`endif
  } ifu_state_e;

  function automatic logic pc_misaligned(input logic [1:0] i_pc_lo);
    return i_pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_npc_gen.sv
// Combinational next-PC mux: sequential pc+4, branch/jal target, or jalr target with bit 0 cleared.
module ifu_npc_gen
  import inst_fetch_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_npc_sel,
  input  logic [XLEN-1:0] i_br_target,
  input  logic [XLEN-1:0] i_jalr_target,
  output logic [XLEN-1:0] o_npc
);

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_jalr_aligned;

  // Wraps modulo 2^XLEN by construction.
  assign w_pc_plus4     = i_pc + XLEN'(4);
  assign w_jalr_aligned = i_jalr_target & ~XLEN'(1);

  always_comb begin
    o_npc = w_pc_plus4;
    case (i_npc_sel)
      NPC_SEL_BR:   o_npc = i_br_target;
      NPC_SEL_JALR: o_npc = w_jalr_aligned;
      default:      o_npc = w_pc_plus4;
    endcase
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding word fetch, instruction held under valid/ready, PC advanced on retire.
// Define IFU_MISALIGN_TRAP_EN to trap on a misaligned PC instead of fetching it.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [31:0]     rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  input  logic [1:0]      npc_sel,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            halt,
  output logic            fetch_fault
);

  ifu_state_e      r_state;
  ifu_state_e      w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] w_npc;
  logic            w_rsp_take;
  logic            w_retire;

  ifu_npc_gen #(
    .XLEN (XLEN)
  ) u_npc_gen (
    .i_pc          (r_pc),
    .i_npc_sel     (npc_sel),
    .i_br_target   (br_target),
    .i_jalr_target (jalr_target),
    .o_npc         (w_npc)
  );

  // Responses arriving in any other state are stale and dropped.
  assign w_rsp_take = (r_state == ST_WAIT) && rsp_valid;
  assign w_retire   = (r_state == ST_HOLD) && instr_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
`ifdef IFU_MISALIGN_TRAP_EN
        w_state_next = pc_misaligned(r_pc[1:0]) ? ST_FAULT : ST_REQ;
`else
        w_state_next = ST_REQ;
`endif
      end
      ST_REQ: begin
        if (req_ready) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (rsp_valid) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (instr_ready) begin
          if (halt) begin
            w_state_next = ST_HALTED;
          end else begin
`ifdef IFU_MISALIGN_TRAP_EN
            w_state_next = pc_misaligned(w_npc[1:0]) ? ST_FAULT : ST_REQ;
`else
            w_state_next = ST_REQ;
`endif
          end
        end
      end
      ST_HALTED: w_state_next = ST_HALTED;
`ifdef IFU_MISALIGN_TRAP_EN
      ST_FAULT:  w_state_next = ST_FAULT;
`endif
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
    end else begin
      r_state <= w_state_next;
      if (w_retire)   r_pc    <= w_npc;
      if (w_rsp_take) r_instr <= rsp_data;
    end
  end

  assign req_valid   = (r_state == ST_REQ);
  assign req_addr    = r_pc;
  assign instr_valid = (r_state == ST_HOLD);
  assign instr       = r_instr;
  assign pc          = r_pc;

`ifdef IFU_MISALIGN_TRAP_EN
  assign fetch_fault = (r_state == ST_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus randomized fetch/retire traffic
// checked against a next-PC reference model kept in the bench.
module tb_inst_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [63:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [1:0]  npc_sel = 2'd0;
  logic [63:0] br_target = '0;
  logic [63:0] jalr_target = '0;
  logic        halt = 1'b0;
  logic        fetch_fault;

  int          n_checks = 0;
  int          n_errors = 0;
  int          hs_count = 0;
  logic [63:0] model_pc;

  inst_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc),
    .npc_sel     (npc_sel),
    .br_target   (br_target),
    .jalr_target (jalr_target),
    .halt        (halt),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) hs_count <= hs_count + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [63:0] ref_npc(input logic [63:0] cur, input logic [1:0] sel,
                                          input logic [63:0] br, input logic [63:0] jalr);
    if (sel == 2'd1) return br;
    if (sel == 2'd2) return jalr - {63'd0, jalr[0]};
    return cur + 64'd4;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; instr_ready = 1'b0; halt = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    model_pc = RST_PC;
  endtask

  // One full fetch/retire transaction with optional stalls and ignored stray responses.
  task automatic do_instr(input logic [31:0] word, input logic [1:0] sel, input logic [63:0] br,
                          input logic [63:0] jalr, input logic hlt, input int req_stall,
                          input int rsp_lat, input int ir_stall, input bit early_rsp);
    int n;
    int hs0;
    n = 0;
    while (req_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("req_valid", {63'd0, req_valid}, 64'd1);
    chk("req_addr", req_addr, model_pc);
    hs0 = hs_count;
    repeat (req_stall) begin
      req_ready = 1'b0;
      tick();
      chk("req_hold_valid", {63'd0, req_valid}, 64'd1);
      chk("req_hold_addr", req_addr, model_pc);
    end
    req_ready = 1'b1;
    if (early_rsp) begin
      rsp_valid = 1'b1;
      rsp_data  = ~word;
    end
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    chk("wait_no_req", {63'd0, req_valid}, 64'd0);
    chk("wait_no_instr", {63'd0, instr_valid}, 64'd0);
    repeat (rsp_lat - 1) begin
      tick();
      chk("wait_idle", {63'd0, instr_valid}, 64'd0);
    end
    rsp_valid = 1'b1;
    rsp_data  = word;
    tick();
    rsp_valid = 1'b0;
    chk("instr_valid", {63'd0, instr_valid}, 64'd1);
    chk("instr", {32'd0, instr}, {32'd0, word});
    chk("pc", pc, model_pc);
    repeat (ir_stall) begin
      instr_ready = 1'b0;
      npc_sel     = 2'($urandom);
      br_target   = {$urandom, $urandom};
      jalr_target = {$urandom, $urandom};
      halt        = 1'b1;
      rsp_valid   = 1'b1;
      rsp_data    = $urandom;
      tick();
      chk("hold_valid", {63'd0, instr_valid}, 64'd1);
      chk("hold_instr", {32'd0, instr}, {32'd0, word});
      chk("hold_pc", pc, model_pc);
      chk("hold_no_req", {63'd0, req_valid}, 64'd0);
    end
    rsp_valid   = 1'b0;
    instr_ready = 1'b1;
    npc_sel     = sel;
    br_target   = br;
    jalr_target = jalr;
    halt        = hlt;
    tick();
    instr_ready = 1'b0;
    halt        = 1'b0;
    model_pc    = ref_npc(model_pc, sel, br, jalr);
    chk("one_handshake", 64'(hs_count), 64'(hs0 + 1));
    chk("retire_drop", {63'd0, instr_valid}, 64'd0);
    if (!hlt && model_pc[1:0] == 2'b00) chk("next_req", {63'd0, req_valid}, 64'd1);
  endtask

  initial begin
    logic [1:0]  r_sel;
    logic [63:0] r_br;
    logic [63:0] r_jalr;
    int          n;

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", {32'd0, instr}, {32'd0, NOP});
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_fault", {63'd0, fetch_fault}, 64'd0);
    rst_n = 1'b1;
    model_pc = RST_PC;

    // First fetch and sequential retires
    do_instr(32'h0010_0093, 2'd0, 64'd0, 64'd0, 1'b0, 0, 1, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      do_instr($urandom, 2'd0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, 1, 0, 1'b0);

    // jalr clears bit 0, then a taken branch
    do_instr($urandom, 2'd2, 64'd0, 64'h8000_0101, 1'b0, 0, 1, 0, 1'b0);
    do_instr($urandom, 2'd1, 64'h8000_0040, 64'd0, 1'b0, 0, 1, 0, 1'b0);

    // Back-pressure on both sides plus stray responses
    do_instr($urandom, 2'd0, 64'd0, 64'd0, 1'b0, 3, 2, 2, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      r_sel  = 2'($urandom);
      r_br   = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
      r_jalr = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFD)};
      do_instr($urandom, r_sel, r_br, r_jalr, 1'b0, $urandom_range(0, 3),
               $urandom_range(1, 3), $urandom_range(0, 3), 1'($urandom));
    end

    // Misaligned branch target
    do_instr($urandom, 2'd1, 64'h8000_0002, 64'd0, 1'b0, 0, 1, 0, 1'b0);
`ifdef IFU_MISALIGN_TRAP_EN
    repeat (4) begin
      chk("fault_flag", {63'd0, fetch_fault}, 64'd1);
      chk("fault_no_req", {63'd0, req_valid}, 64'd0);
      chk("fault_no_instr", {63'd0, instr_valid}, 64'd0);
      tick();
    end
    reset_dut();
`else
    do_instr($urandom, 2'd1, 64'h8000_0200, 64'd0, 1'b0, 0, 1, 0, 1'b0);
    chk("no_fault", {63'd0, fetch_fault}, 64'd0);
`endif

    // ebreak with halt: fetching stops
    do_instr(32'h0010_0073, 2'd0, 64'd0, 64'd0, 1'b1, 0, 1, 0, 1'b0);
    repeat (5) begin
      req_ready = 1'b1;
      tick();
      chk("halted_no_req", {63'd0, req_valid}, 64'd0);
      chk("halted_no_instr", {63'd0, instr_valid}, 64'd0);
    end
    req_ready = 1'b0;

    // Reset in the middle of WAIT; the late response must be dropped
    reset_dut();
    n = 0;
    while (req_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("mid_req_valid", {63'd0, req_valid}, 64'd1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {63'd0, req_valid}, 64'd0);
    chk("async_rst_pc", pc, RST_PC);
    tick();
    rst_n = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    chk("stale_rsp_valid", {63'd0, instr_valid}, 64'd0);
    chk("stale_rsp_instr", {32'd0, instr}, {32'd0, NOP});
    model_pc = RST_PC;
    do_instr(32'h0000_0513, 2'd0, 64'd0, 64'd0, 1'b0, 0, 1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
